// File: rtl/inputc_mvc.sv
// Multi-VC router input controller: per-VC FIFOs, wormhole VC FSMs and a round-robin switch request.
// Define INPUTC_MVC_ERRCHK_EN to enable the sticky overflow flag on err (otherwise err is tied low).
//
// state    | meaning
// S_IDLE   | FIFO empty, or front flit is not a head
// S_WAIT   | head flit at front, output port latched, competing for the switch
// S_ACTIVE | packet granted; VC holds the switch lock until its tail is sent
module inputc_mvc #(
  parameter int NVC   = 4,
  parameter int VCW   = 2,
  parameter int DATAW = 64,
  parameter int DEPTH = 4,
  parameter int PORTW = 3
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW-1:0] idata,
  input  logic             ivalid,
  input  logic [VCW-1:0]   ivch,
  output logic [NVC-1:0]   ordy,
  output logic [NVC-1:0]   oack,
  output logic [DATAW-1:0] odata,
  output logic             ovalid,
  output logic [VCW-1:0]   ovch,
  output logic             req,
  output logic [PORTW-1:0] port,
  input  logic             grt,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = VCW + 1;
  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE} vc_state_e;

  logic [DATAW-1:0] mem     [NVC][DEPTH];
  logic [AW-1:0]    wr_ptr  [NVC];
  logic [AW-1:0]    rd_ptr  [NVC];
  logic [CW-1:0]    cnt     [NVC];
  vc_state_e        state_q [NVC];
  vc_state_e        state_d [NVC];
  logic [PORTW-1:0] port_q  [NVC];
  logic [PORTW-1:0] port_d  [NVC];
  logic [DATAW-1:0] head    [NVC];
  logic [NVC-1:0]   wr_en;
  logic [NVC-1:0]   pop;
  logic [NVC-1:0]   full;
  logic [VCW-1:0]   sel_q;
  logic [VCW-1:0]   rr_q;
  logic [VCW-1:0]   sel;
  logic [VCW-1:0]   rr_next;
  logic [SW-1:0]    arb_sum;
  logic             arb_hit;
  logic             send;
  logic [1:0]       in_type;

  function automatic logic is_head(input logic [1:0] t);
    return (t == T_HEAD) || (t == T_HT);
  endfunction

  assign in_type = idata[DATAW-1:DATAW-2];

  always_comb begin : fifo_status
    for (int v = 0; v < NVC; v++) begin
      head[v] = mem[v][rd_ptr[v]];
      full[v] = (cnt[v] == CW'(DEPTH));
    end
  end

  assign ordy = ~full;

  // The selection is frozen while the selected VC owns the switch; otherwise scan from rr_q.
  always_comb begin : arbiter
    sel     = sel_q;
    arb_hit = 1'b0;
    arb_sum = '0;
    if (state_q[sel_q] != S_ACTIVE) begin
      for (int i = 0; i < NVC; i++) begin
        arb_sum = {1'b0, rr_q} + SW'(i);
        if (arb_sum >= SW'(NVC)) arb_sum = arb_sum - SW'(NVC);
        if (!arb_hit && state_q[arb_sum[VCW-1:0]] == S_WAIT) begin
          sel     = arb_sum[VCW-1:0];
          arb_hit = 1'b1;
        end
      end
    end
    rr_next = (sel == VCW'(NVC - 1)) ? '0 : sel + 1'b1;
  end

  always_comb begin : outputs
    req    = (state_q[sel] == S_WAIT) || (state_q[sel] == S_ACTIVE && cnt[sel] != '0);
    send   = req && grt;
    ovalid = send;
    ovch   = sel;
    port   = port_q[sel];
    odata  = send ? head[sel] : '0;
    oack   = '0;
    if (send) oack[sel] = 1'b1;
  end

  // A write to a full FIFO is accepted only when the same edge pops it.
  always_comb begin : fifo_ctrl
    for (int v = 0; v < NVC; v++) begin
      pop[v]   = send && (sel == VCW'(v));
      wr_en[v] = ivalid && (ivch == VCW'(v)) && (!full[v] || pop[v]);
    end
  end

  always_comb begin : next_state
    for (int v = 0; v < NVC; v++) begin
      state_d[v] = state_q[v];
      port_d[v]  = port_q[v];
      case (state_q[v])
        S_IDLE: begin
          if (cnt[v] != '0) begin
            if (is_head(head[v][DATAW-1:DATAW-2])) begin
              state_d[v] = S_WAIT;
              port_d[v]  = head[v][PORTW-1:0];
            end
          end else if (wr_en[v] && is_head(in_type)) begin
            state_d[v] = S_WAIT;
            port_d[v]  = idata[PORTW-1:0];
          end
        end
        S_WAIT: begin
          if (pop[v])
            state_d[v] = (head[v][DATAW-1:DATAW-2] == T_HT) ? S_IDLE : S_ACTIVE;
        end
        S_ACTIVE: begin
          if (pop[v] && (head[v][DATAW-1:DATAW-2] == T_TAIL ||
                         head[v][DATAW-1:DATAW-2] == T_HT))
            state_d[v] = S_IDLE;
        end
        default: state_d[v] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin : state_reg
    if (!rst_) begin
      for (int v = 0; v < NVC; v++) begin
        state_q[v] <= S_IDLE;
        port_q[v]  <= '0;
      end
      sel_q <= '0;
      rr_q  <= '0;
    end else begin
      for (int v = 0; v < NVC; v++) begin
        state_q[v] <= state_d[v];
        port_q[v]  <= port_d[v];
      end
      if (send) begin
        sel_q <= sel;
        if (state_q[sel] == S_WAIT) rr_q <= rr_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin : fifo_ptrs
    if (!rst_) begin
      for (int v = 0; v < NVC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        cnt[v]    <= '0;
      end
    end else begin
      for (int v = 0; v < NVC; v++) begin
        if (wr_en[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
        if (pop[v])   rd_ptr[v] <= rd_ptr[v] + 1'b1;
        case ({wr_en[v], pop[v]})
          2'b10:   cnt[v] <= cnt[v] + 1'b1;
          2'b01:   cnt[v] <= cnt[v] - 1'b1;
          default: cnt[v] <= cnt[v];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin : fifo_mem
    for (int v = 0; v < NVC; v++) begin
      if (wr_en[v]) mem[v][wr_ptr[v]] <= idata;
    end
  end

`ifdef INPUTC_MVC_ERRCHK_EN
  always_ff @(posedge clk or negedge rst_) begin : err_reg
    if (!rst_)
      err <= 1'b0;
    else if (ivalid && full[ivch] && !pop[ivch])
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_inputc_mvc.sv
// Directed bench for inputc_mvc: reset, wormhole transfer, round-robin, lock, full FIFO, async reset.
module tb_inputc_mvc;

  localparam logic [1:0] H  = 2'b00;
  localparam logic [1:0] B  = 2'b01;
  localparam logic [1:0] T  = 2'b10;
  localparam logic [1:0] HT = 2'b11;
`ifdef INPUTC_MVC_ERRCHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic [63:0] idata = '0;
  logic        ivalid = 1'b0;
  logic [1:0]  ivch = '0;
  logic        grt = 1'b0;
  logic [3:0]  ordy, oack;
  logic [63:0] odata;
  logic        ovalid, req, err;
  logic [1:0]  ovch;
  logic [2:0]  port;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inputc_mvc dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .ordy(ordy), .oack(oack), .odata(odata), .ovalid(ovalid), .ovch(ovch),
    .req(req), .port(port), .grt(grt), .err(err)
  );

  function automatic logic [63:0] fl(input logic [1:0] t, input logic [15:0] tag, input logic [2:0] p);
    return {t, 43'd0, tag, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    ivalid = 1'b0;
    grt    = 1'b0;
    rst_   = 1'b0;
    #2;
    rst_   = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ordy, oack, ovalid, ovch, req, port, err} !== {4'hF, 4'h0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl got=%h exp=%h", {ordy, oack, ovalid, ovch, req, port, err},
               {4'hF, 4'h0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0});
    end
    checks++;
    if (odata !== 64'd0) begin
      errors++;
      $display("FAIL reset_odata got=%h exp=0", odata);
    end
    rst_ = 1'b1;
  endtask

  task automatic test_packet();
    logic [63:0] exp_d [3];
    do_reset();
    grt = 1'b1;
    exp_d[0] = fl(H, 16'h0A, 3'd4);
    exp_d[1] = fl(B, 16'h0B, 3'd0);
    exp_d[2] = fl(T, 16'h0C, 3'd0);
    tick();
    ivalid = 1'b1; ivch = 2'd2; idata = exp_d[0];
    #1;
    checks++;
    if (req !== 1'b0) begin
      errors++;
      $display("FAIL pkt_cycle0_req got=%b exp=0", req);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k < 2) idata = exp_d[k+1];
      else ivalid = 1'b0;
      #1;
      checks++;
      if ({req, ovalid, ovch, port, oack} !== {1'b1, 1'b1, 2'd2, 3'd4, 4'b0100}) begin
        errors++;
        $display("FAIL pkt_ctl_%0d got=%h exp=%h", k, {req, ovalid, ovch, port, oack},
                 {1'b1, 1'b1, 2'd2, 3'd4, 4'b0100});
      end
      checks++;
      if (odata !== exp_d[k]) begin
        errors++;
        $display("FAIL pkt_data_%0d got=%h exp=%h", k, odata, exp_d[k]);
      end
    end
    tick();
    checks++;
    if ({req, ovalid, oack, ordy} !== {1'b0, 1'b0, 4'h0, 4'hF} || odata !== 64'd0) begin
      errors++;
      $display("FAIL pkt_done got=%h/%h exp=%h/0", {req, ovalid, oack, ordy}, odata,
               {1'b0, 1'b0, 4'h0, 4'hF});
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] vcs [3];
    logic [2:0] pts [3];
    vcs = '{2'd0, 2'd1, 2'd3};
    pts = '{3'd1, 3'd2, 3'd5};
    do_reset();
    tick(); ivalid = 1'b1; ivch = 2'd0; idata = fl(HT, 16'h10, 3'd1);
    tick(); ivch = 2'd1; idata = fl(HT, 16'h11, 3'd2);
    tick(); ivch = 2'd3; idata = fl(HT, 16'h13, 3'd5);
    tick(); ivalid = 1'b0; grt = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ovalid, ovch, port, oack} !== {1'b1, vcs[k], pts[k], 4'b0001 << vcs[k]}) begin
        errors++;
        $display("FAIL rr_ctl_%0d got=%h exp=%h", k, {ovalid, ovch, port, oack},
                 {1'b1, vcs[k], pts[k], 4'b0001 << vcs[k]});
      end
      checks++;
      if (odata !== fl(HT, 16'h10 + 16'(vcs[k]), pts[k])) begin
        errors++;
        $display("FAIL rr_data_%0d got=%h exp=%h", k, odata, fl(HT, 16'h10 + 16'(vcs[k]), pts[k]));
      end
      tick();
    end
    checks++;
    if (req !== 1'b0) begin
      errors++;
      $display("FAIL rr_drained_req got=%b exp=0", req);
    end
    grt = 1'b0; ivalid = 1'b1; ivch = 2'd3; idata = fl(HT, 16'h23, 3'd6);
    tick(); ivch = 2'd0; idata = fl(HT, 16'h20, 3'd7);
    tick(); ivalid = 1'b0; grt = 1'b1;
    #1;
    checks++;
    if ({ovch, port} !== {2'd0, 3'd7} || odata !== fl(HT, 16'h20, 3'd7)) begin
      errors++;
      $display("FAIL rr_wrap_first got=%h/%h exp=%h", {ovch, port}, odata, {2'd0, 3'd7});
    end
    tick();
    checks++;
    if ({ovch, port} !== {2'd3, 3'd6} || odata !== fl(HT, 16'h23, 3'd6)) begin
      errors++;
      $display("FAIL rr_wrap_second got=%h/%h exp=%h", {ovch, port}, odata, {2'd3, 3'd6});
    end
    grt = 1'b0;
  endtask

  task automatic test_lock();
    do_reset();
    tick(); ivalid = 1'b1; ivch = 2'd1; idata = fl(H, 16'h51, 3'd2);
    tick(); ivch = 2'd0; idata = fl(H, 16'h50, 3'd3); grt = 1'b1;
    #1;
    checks++;
    if ({ovalid, ovch, port, oack} !== {1'b1, 2'd1, 3'd2, 4'b0010} || odata !== fl(H, 16'h51, 3'd2)) begin
      errors++;
      $display("FAIL lock_head got=%h/%h exp=%h", {ovalid, ovch, port, oack}, odata,
               {1'b1, 2'd1, 3'd2, 4'b0010});
    end
    tick(); ivalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin ivalid = 1'b1; ivch = 2'd1; idata = fl(B, 16'h52, 3'd0); end
      #1;
      checks++;
      if ({req, ovalid, ovch, oack} !== {1'b0, 1'b0, 2'd1, 4'h0}) begin
        errors++;
        $display("FAIL lock_gap_%0d got=%h exp=%h", k, {req, ovalid, ovch, oack}, {1'b0, 1'b0, 2'd1, 4'h0});
      end
      tick();
    end
    idata = fl(T, 16'h53, 3'd0);
    #1;
    checks++;
    if ({ovalid, ovch} !== {1'b1, 2'd1} || odata !== fl(B, 16'h52, 3'd0)) begin
      errors++;
      $display("FAIL lock_body got=%h/%h exp=%h", {ovalid, ovch}, odata, {1'b1, 2'd1});
    end
    tick(); ivalid = 1'b0;
    #1;
    checks++;
    if ({ovalid, ovch} !== {1'b1, 2'd1} || odata !== fl(T, 16'h53, 3'd0)) begin
      errors++;
      $display("FAIL lock_tail got=%h/%h exp=%h", {ovalid, ovch}, odata, {1'b1, 2'd1});
    end
    tick();
    checks++;
    if ({ovalid, ovch, port, oack} !== {1'b1, 2'd0, 3'd3, 4'b0001} || odata !== fl(H, 16'h50, 3'd3)) begin
      errors++;
      $display("FAIL lock_release got=%h/%h exp=%h", {ovalid, ovch, port, oack}, odata,
               {1'b1, 2'd0, 3'd3, 4'b0001});
    end
    grt = 1'b0;
  endtask

  task automatic test_full();
    logic [63:0] exp_d;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      ivalid = 1'b1; ivch = 2'd0;
      idata = (k == 0) ? fl(H, 16'h30, 3'd1) : fl(B, 16'h30 + 16'(k), 3'd0);
    end
    tick(); idata = fl(B, 16'h34, 3'd0);
    #1;
    checks++;
    if ({ordy, req, ovalid} !== {4'b1110, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL full_ordy got=%h exp=%h", {ordy, req, ovalid}, {4'b1110, 1'b1, 1'b0});
    end
    tick(); idata = fl(T, 16'h35, 3'd0); grt = 1'b1;
    #1;
    checks++;
    if ({err, ordy} !== {EXP_ERR, 4'b1110}) begin
      errors++;
      $display("FAIL full_overflow got=%h exp=%h", {err, ordy}, {EXP_ERR, 4'b1110});
    end
    checks++;
    if ({ovalid, oack} !== {1'b1, 4'b0001} || odata !== fl(H, 16'h30, 3'd1)) begin
      errors++;
      $display("FAIL full_pop_head got=%h/%h exp=%h", {ovalid, oack}, odata, {1'b1, 4'b0001});
    end
    tick(); ivalid = 1'b0;
    #1;
    checks++;
    if ({err, ordy} !== {EXP_ERR, 4'b1110} || odata !== fl(B, 16'h31, 3'd0)) begin
      errors++;
      $display("FAIL full_simul got=%h/%h exp=%h", {err, ordy}, odata, {EXP_ERR, 4'b1110});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_d = (k < 2) ? fl(B, 16'h32 + 16'(k), 3'd0) : fl(T, 16'h35, 3'd0);
      checks++;
      if (ovalid !== 1'b1 || odata !== exp_d) begin
        errors++;
        $display("FAIL full_drain_%0d got=%h exp=%h", k, odata, exp_d);
      end
    end
    tick();
    checks++;
    if ({ovalid, ordy} !== {1'b0, 4'hF}) begin
      errors++;
      $display("FAIL full_empty got=%h exp=%h", {ovalid, ordy}, {1'b0, 4'hF});
    end
    grt = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(); ivalid = 1'b1; ivch = 2'd2; idata = fl(H, 16'h40, 3'd4);
    tick(); idata = fl(B, 16'h41, 3'd0);
    tick(); ivalid = 1'b0; grt = 1'b1;
    #1;
    checks++;
    if ({ovalid, oack} !== {1'b1, 4'b0100}) begin
      errors++;
      $display("FAIL arst_pre got=%h exp=%h", {ovalid, oack}, {1'b1, 4'b0100});
    end
    #2;
    rst_ = 1'b0;
    #1;
    checks++;
    if ({ordy, oack, ovalid, ovch, req, port, err} !== {4'hF, 4'h0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0}
        || odata !== 64'd0) begin
      errors++;
      $display("FAIL arst_immediate got=%h/%h exp=%h", {ordy, oack, ovalid, ovch, req, port, err}, odata,
               {4'hF, 4'h0, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0});
    end
    tick();
    checks++;
    if ({oack, ovalid} !== 5'd0) begin
      errors++;
      $display("FAIL arst_no_ack got=%h exp=0", {oack, ovalid});
    end
    rst_ = 1'b1;
    ivalid = 1'b1; ivch = 2'd2; idata = fl(H, 16'h50, 3'd6);
    tick(); ivalid = 1'b0;
    #1;
    checks++;
    if ({ovalid, ovch, port, oack} !== {1'b1, 2'd2, 3'd6, 4'b0100} || odata !== fl(H, 16'h50, 3'd6)) begin
      errors++;
      $display("FAIL arst_new_head got=%h/%h exp=%h", {ovalid, ovch, port, oack}, odata,
               {1'b1, 2'd2, 3'd6, 4'b0100});
    end
    tick();
    checks++;
    if ({req, ovch} !== {1'b0, 2'd2}) begin
      errors++;
      $display("FAIL arst_discarded got=%h exp=%h", {req, ovch}, {1'b0, 2'd2});
    end
    grt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_packet();
    test_round_robin();
    test_lock();
    test_full();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
